z80_shift_seq: RTL and testbench
================================

# z80_shift_seq

Sequential, parametrised rotate/shift engine for the Z80 core's CB-prefix and accumulator rotate paths. It executes any rotate/shift opcode, plus RLD/RRD, for a programmable count of 1-bit steps, with the carry chained between steps. Z80 flags are computed on the final result. It sits beside the ALU in the execute stage and is controlled by the sequencer through a start/done handshake.

## Interface
- WIDTH, 8 — operand width; 8 or 16.
- CNT_W, 4 — width of the step-count input.

- clk  in  1 — clock, rising edge.
- reset_n  in  1 — asynchronous, active-low reset.
- start  in  1 — request; accepted in IDLE or DONE.
- op  in  4 — operation code, listed below.
- count  in  CNT_W — number of steps; 0 is treated as 1.
- data_in  in  WIDTH — operand (register or memory byte/word).
- acc_in  in  8 — accumulator; used by RLD/RRD only.
- flags_in  in  8 — incoming F register, bit order S Z Y H X P N C (7..0).
- busy  out  1 — high while in SHIFT.
- done  out  1 — one-cycle pulse; outputs are valid.
- err  out  1 — high with done when op was illegal.
- data_out  out  WIDTH — result.
- acc_out  out  8 — accumulator result (RLD/RRD; otherwise acc_in).
- flags_out  out  8 — resulting F.

## Operation
- Op codes: 0 RLC, 1 RLCA, 2 RRC, 3 RRCA, 4 RL, 5 RLA, 6 RR, 7 RRA, 8 SLA, 9 SRA, A SRL, B SLL (shift in 1), C RLD, D RRD, E/F illegal.
- Each step applies one 1-bit operation across the full WIDTH. C from step k feeds RL/RR at step k+1.
- Final flags:
  - C = last bit shifted out.
  - H = N = 0.
  - Y (bit 5) and X (bit 3) pass through from flags_in.
- Non-A ops (RLC, RRC, RL, RR, SLA, SRA, SRL, SLL):
  - S = result[WIDTH-1].
  - Z = (result == 0).
  - P = even parity of the full result. For SLL, Z and P use the true result, including the shifted-in 1.
- A ops (RLCA, RRCA, RLA, RRA): S, Z and P are preserved from flags_in.
- RLD/RRD: single step regardless of count; they operate on data_in[7:0].
  - RLD: acc_out = {acc[7:4], d[7:4]}, d' = {d[3:0], acc[3:0]}.
  - RRD: acc_out = {acc[7:4], d[3:0]}, d' = {acc[3:0], d[7:4]}.
  - data_out[WIDTH-1:8] is unchanged. S, Z and P come from acc_out; C is preserved.
- Illegal op: one step, data_out = data_in, acc_out = acc_in, flags_out = flags_in, err = 1.

## Timing
- States:
  - IDLE → SHIFT on start. Operands are latched; remaining = max(count, 1), or 1 for RLD/RRD/illegal.
  - SHIFT performs one step per cycle and decrements remaining. When remaining == 1, it → DONE.
  - DONE: done = 1 for exactly one cycle, then → IDLE, or → SHIFT if start is high (back-to-back).
- Latency: done is high N+1 cycles after the start edge, where N is the step count.
- start is ignored while busy. Inputs are sampled only at acceptance; later changes to them have no effect.
- data_out, acc_out, flags_out and err hold their values from done until the next acceptance. They are undefined-but-stable during SHIFT and must not be consumed then.
- Reset (any time, including mid-SHIFT): state IDLE; busy, done and err are 0; data_out, acc_out and flags_out are all 0. No done is produced for the aborted operation.

## Structure
- Shared package z80_shift_pkg holds:
  - op-code constants,
  - flag bit indices (S=7, Z=6, Y=5, H=4, X=3, P=2, N=1, C=0),
  - the state encoding (IDLE, SHIFT, DONE).
- One combinational sub-module, z80_shift_step. It takes (op, value, carry) and returns (value', carry_out) for a single step. It is parametrised by WIDTH and instantiated once.
- The top level holds the FSM, the step counter, the operand/carry registers, and final flag generation.

## Test plan
- WIDTH=8, RLC 0x81, count 1, flags_in 0x00 → data_out 0x03, flags_out 0x05, done at cycle 2.
- RL 0x80, count 3, flags_in 0x01 → data_out 0x06, flags_out 0x04, busy for 3 cycles, done at cycle 4.
- SRL 0x01 → data_out 0x00, flags_out 0x45. SLL 0x80 → data_out 0x01, flags_out 0x01.
- RLD, acc 0x7A, data 0x31, flags_in 0x01, count 7 → acc_out 0x73, data_out 0x1A, flags_out 0x01, done at cycle 2.
- WIDTH=16, SRA 0x8001, count 4 → data_out 0xF800, flags_out 0x80. A start pulsed during busy is ignored.
- Reset asserted mid-SHIFT on a count-10 op → all outputs 0, no done. Op F → err = 1, outputs equal inputs.

Source files
------------

// File: rtl/z80_shift_pkg.sv
// rtl/z80_shift_pkg.sv - shared op codes, flag indices and state encoding for the shift engine
package z80_shift_pkg;

  localparam logic [3:0] OP_RLC  = 4'h0;
  localparam logic [3:0] OP_RLCA = 4'h1;
  localparam logic [3:0] OP_RRC  = 4'h2;
  localparam logic [3:0] OP_RRCA = 4'h3;
  localparam logic [3:0] OP_RL   = 4'h4;
  localparam logic [3:0] OP_RLA  = 4'h5;
  localparam logic [3:0] OP_RR   = 4'h6;
  localparam logic [3:0] OP_RRA  = 4'h7;
  localparam logic [3:0] OP_SLA  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;
  localparam logic [3:0] OP_SLL  = 4'hB;
  localparam logic [3:0] OP_RLD  = 4'hC;
  localparam logic [3:0] OP_RRD  = 4'hD;

  localparam int F_S = 7;
  localparam int F_Z = 6;
  localparam int F_Y = 5;
  localparam int F_H = 4;
  localparam int F_X = 3;
  localparam int F_P = 2;
  localparam int F_N = 1;
  localparam int F_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= 4'hE;
  endfunction

  function automatic logic is_rxd(input logic [3:0] op);
    return (op == OP_RLD) || (op == OP_RRD);
  endfunction

  function automatic logic is_a_op(input logic [3:0] op);
    return (op == OP_RLCA) || (op == OP_RRCA) || (op == OP_RLA) || (op == OP_RRA);
  endfunction

endpackage

// File: rtl/z80_shift_if.sv
// rtl/z80_shift_if.sv - start/done request bus between the sequencer and the shift engine
interface z80_shift_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [3:0]       op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_in;
  logic [7:0]       acc_in;
  logic [7:0]       flags_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] data_out;
  logic [7:0]       acc_out;
  logic [7:0]       flags_out;

  modport master (
    output start, op, count, data_in, acc_in, flags_in,
    input  busy, done, err, data_out, acc_out, flags_out
  );

  modport slave (
    input  start, op, count, data_in, acc_in, flags_in,
    output busy, done, err, data_out, acc_out, flags_out
  );
endinterface

// File: rtl/z80_shift_step.sv
// rtl/z80_shift_step.sv - one 1-bit rotate/shift step across the full operand
module z80_shift_step
  import z80_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] value,
  input  logic             carry,
  output logic [WIDTH-1:0] value_out,
  output logic             carry_out
);

  logic msb, lsb;

  always_comb begin
    msb       = value[WIDTH-1];
    lsb       = value[0];
    value_out = value;
    carry_out = carry;
    case (op)
      OP_RLC, OP_RLCA: begin value_out = {value[WIDTH-2:0], msb};   carry_out = msb; end
      OP_RRC, OP_RRCA: begin value_out = {lsb, value[WIDTH-1:1]};   carry_out = lsb; end
      OP_RL,  OP_RLA:  begin value_out = {value[WIDTH-2:0], carry}; carry_out = msb; end
      OP_RR,  OP_RRA:  begin value_out = {carry, value[WIDTH-1:1]}; carry_out = lsb; end
      OP_SLA:          begin value_out = {value[WIDTH-2:0], 1'b0};  carry_out = msb; end
      OP_SRA:          begin value_out = {msb, value[WIDTH-1:1]};   carry_out = lsb; end
      OP_SRL:          begin value_out = {1'b0, value[WIDTH-1:1]};  carry_out = lsb; end
      OP_SLL:          begin value_out = {value[WIDTH-2:0], 1'b1};  carry_out = msb; end
      // RLD/RRD and illegal ops are resolved in the top level
      default: ;
    endcase
  end

endmodule

// File: rtl/z80_shift_seq.sv
// rtl/z80_shift_seq.sv - multi-step rotate/shift sequencer with Z80 flag generation
module z80_shift_seq
  import z80_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic       clk,
  input logic       reset_n,
  z80_shift_if.slave bus
);

  state_t           state, state_n;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] val_r;
  logic             carry_r;
  logic [7:0]       acc_r, flags_r;
  logic [CNT_W-1:0] remaining;

  logic [WIDTH-1:0] step_val;
  logic             step_c;
  logic             accept, last_step, busy, done;
  logic [WIDTH-1:0] res;
  logic [7:0]       acc_res, flags_res;

  logic [WIDTH-1:0] data_q;
  logic [7:0]       acc_q, flags_q;
  logic             err_q;

  z80_shift_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_r),
    .value     (val_r),
    .carry     (carry_r),
    .value_out (step_val),
    .carry_out (step_c)
  );

  assign accept    = bus.start && (state != ST_SHIFT);
  assign last_step = (state == ST_SHIFT) && (remaining == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_n = ST_SHIFT;
      ST_SHIFT: begin
        busy = 1'b1;
        if (remaining == CNT_W'(1)) state_n = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = accept ? ST_SHIFT : ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  // Result and flags of the current step; only consumed on the last one
  always_comb begin
    res            = step_val;
    acc_res        = acc_r;
    flags_res      = flags_r;
    flags_res[F_H] = 1'b0;
    flags_res[F_N] = 1'b0;
    if (op_r == OP_RLD) begin
      res      = val_r;
      res[7:0] = {val_r[3:0], acc_r[3:0]};
      acc_res  = {acc_r[7:4], val_r[7:4]};
    end else if (op_r == OP_RRD) begin
      res      = val_r;
      res[7:0] = {acc_r[3:0], val_r[7:4]};
      acc_res  = {acc_r[7:4], val_r[3:0]};
    end
    if (is_illegal(op_r)) begin
      res       = val_r;
      flags_res = flags_r;
    end else if (is_rxd(op_r)) begin
      flags_res[F_S] = acc_res[7];
      flags_res[F_Z] = (acc_res == 8'h00);
      flags_res[F_P] = ~^acc_res;
    end else if (is_a_op(op_r)) begin
      flags_res[F_C] = step_c;
    end else begin
      flags_res[F_S] = res[WIDTH-1];
      flags_res[F_Z] = (res == '0);
      flags_res[F_P] = ~^res;
      flags_res[F_C] = step_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r      <= '0;
      val_r     <= '0;
      carry_r   <= 1'b0;
      acc_r     <= '0;
      flags_r   <= '0;
      remaining <= '0;
      data_q    <= '0;
      acc_q     <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      op_r    <= bus.op;
      val_r   <= bus.data_in;
      carry_r <= bus.flags_in[F_C];
      acc_r   <= bus.acc_in;
      flags_r <= bus.flags_in;
      if (is_illegal(bus.op) || is_rxd(bus.op) || (bus.count == '0))
        remaining <= CNT_W'(1);
      else
        remaining <= bus.count;
    end else if (state == ST_SHIFT) begin
      val_r     <= res;
      carry_r   <= step_c;
      remaining <= remaining - CNT_W'(1);
      if (last_step) begin
        data_q  <= res;
        acc_q   <= acc_res;
        flags_q <= flags_res;
        err_q   <= is_illegal(op_r);
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err_q;
  assign bus.data_out  = data_q;
  assign bus.acc_out   = acc_q;
  assign bus.flags_out = flags_q;

endmodule

// File: tb/tb_z80_shift_seq.sv
// tb/tb_z80_shift_seq.sv - directed self-checking bench for the 8- and 16-bit shift engine
module tb_z80_shift_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  z80_shift_if #(.WIDTH(8),  .CNT_W(4)) if8 ();
  z80_shift_if #(.WIDTH(16), .CNT_W(4)) if16 ();

  z80_shift_seq #(.WIDTH(8),  .CNT_W(4)) dut8  (.clk(clk), .reset_n(reset_n), .bus(if8.slave));
  z80_shift_seq #(.WIDTH(16), .CNT_W(4)) dut16 (.clk(clk), .reset_n(reset_n), .bus(if16.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w16, input logic s, input logic [3:0] op, input logic [3:0] cnt,
                       input logic [15:0] d, input logic [7:0] a, input logic [7:0] f);
    if (w16) begin
      if16.start = s; if16.op = op; if16.count = cnt;
      if16.data_in = d; if16.acc_in = a; if16.flags_in = f;
    end else begin
      if8.start = s; if8.op = op; if8.count = cnt;
      if8.data_in = d[7:0]; if8.acc_in = a; if8.flags_in = f;
    end
  endtask

  task automatic run_op(input string tag, input bit w16, input logic [3:0] op, input logic [3:0] cnt,
                        input logic [15:0] d, input logic [7:0] a, input logic [7:0] f,
                        input logic [15:0] ed, input logic [7:0] ea, input logic [7:0] ef,
                        input logic ee, input int elat, input bit poke);
    int cyc = 0;
    int busy_n = 0;
    bit got_done = 0;
    logic [15:0] dout;
    logic [7:0] aout, fout;
    logic eout;
    @(negedge clk);
    drive(w16, 1'b1, op, cnt, d, a, f);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance: they must have no further effect
    drive(w16, 1'b0, ~op, ~cnt, ~d, ~a, ~f);
    while (cyc < 40 && !got_done) begin
      @(negedge clk);
      cyc++;
      if (w16 ? if16.busy : if8.busy) busy_n++;
      if (w16 ? if16.done : if8.done) got_done = 1;
      if (poke && cyc == 2) drive(w16, 1'b1, 4'h0, 4'h1, 16'h1234, 8'h00, 8'h00);
      if (poke && cyc == 3) drive(w16, 1'b0, 4'h0, 4'h1, 16'h1234, 8'h00, 8'h00);
    end
    dout = w16 ? if16.data_out : {8'h00, if8.data_out};
    aout = w16 ? if16.acc_out : if8.acc_out;
    fout = w16 ? if16.flags_out : if8.flags_out;
    eout = w16 ? if16.err : if8.err;
    check({tag, ".done"}, 32'(got_done), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'(elat));
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(elat - 1));
    check({tag, ".data_out"}, 32'(dout), 32'(ed));
    check({tag, ".acc_out"}, 32'(aout), 32'(ea));
    check({tag, ".flags_out"}, 32'(fout), 32'(ef));
    check({tag, ".err"}, 32'(eout), 32'(ee));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(w16 ? if16.done : if8.done), 32'd0);
    check({tag, ".data_hold"}, 32'(w16 ? if16.data_out : {8'h00, if8.data_out}), 32'(ed));
  endtask

  initial begin
    int done_seen;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 16'h0000, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset.busy", 32'(if8.busy), 32'd0);
    check("reset.done", 32'(if8.done), 32'd0);
    check("reset.err", 32'(if8.err), 32'd0);
    check("reset.data_out", 32'(if16.data_out), 32'd0);
    check("reset.flags_out", 32'(if8.flags_out), 32'd0);

    //      tag      w16  op     cnt   data      acc    flags  exp_d     exp_a  exp_f  err lat poke
    run_op("rlc",    0, 4'h0, 4'd1, 16'h0081, 8'h00, 8'h00, 16'h0003, 8'h00, 8'h05, 0, 2, 0);
    run_op("rl3",    0, 4'h4, 4'd3, 16'h0080, 8'h00, 8'h01, 16'h0006, 8'h00, 8'h04, 0, 4, 0);
    run_op("srl",    0, 4'hA, 4'd1, 16'h0001, 8'h00, 8'h00, 16'h0000, 8'h00, 8'h45, 0, 2, 0);
    run_op("sll",    0, 4'hB, 4'd1, 16'h0080, 8'h00, 8'h00, 16'h0001, 8'h00, 8'h01, 0, 2, 0);
    run_op("cnt0",   0, 4'h8, 4'd0, 16'h00C0, 8'h00, 8'h28, 16'h0080, 8'h00, 8'hA9, 0, 2, 0);
    run_op("rla",    0, 4'h5, 4'd2, 16'h00C0, 8'h11, 8'hC4, 16'h0001, 8'h11, 8'hC5, 0, 3, 0);
    run_op("rld",    0, 4'hC, 4'd7, 16'h0031, 8'h7A, 8'h01, 16'h001A, 8'h73, 8'h01, 0, 2, 0);
    run_op("rrd",    0, 4'hD, 4'd1, 16'h0031, 8'h7A, 8'h00, 16'h00A3, 8'h71, 8'h04, 0, 2, 0);
    run_op("sra16",  1, 4'h9, 4'd4, 16'h8001, 8'h00, 8'h00, 16'hF800, 8'h00, 8'h80, 0, 5, 1);
    run_op("rld16",  1, 4'hC, 4'd1, 16'hAB31, 8'h7A, 8'h00, 16'hAB1A, 8'h73, 8'h00, 0, 2, 0);
    run_op("illegal",0, 4'hF, 4'd5, 16'h005A, 8'h33, 8'hA5, 16'h005A, 8'h33, 8'hA5, 1, 2, 0);

    // Reset in the middle of a long operation
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h4, 4'd10, 16'h00FF, 8'h00, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h4, 4'd10, 16'h00FF, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("midrst.busy_before", 32'(if8.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst.busy", 32'(if8.busy), 32'd0);
    check("midrst.done", 32'(if8.done), 32'd0);
    check("midrst.err", 32'(if8.err), 32'd0);
    check("midrst.data_out", 32'(if8.data_out), 32'd0);
    check("midrst.acc_out", 32'(if8.acc_out), 32'd0);
    check("midrst.flags_out", 32'(if8.flags_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (if8.done) done_seen++;
    end
    check("midrst.no_done", 32'(done_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
